// File: rtl/sd_spi_responder_if.sv
// ---------------------------------------------------------------------------
// sd_spi_responder_if
//   Groups the SPI pins and the block-memory read port of the SD card
//   emulator.
//
//   sclk      host SPI clock (idle low, mode 0)
//   cs        host chip select, active low
//   mosi      host-to-card serial data
//   miso      card-to-host serial data
//   mem_addr  byte address into the card's block memory
//   mem_data  memory read data, valid one clock after mem_addr
//
//   Modports:
//     master  host / system side (drives SPI pins, supplies memory data)
//     slave   card side (sd_spi_responder)
// ---------------------------------------------------------------------------
interface sd_spi_responder_if #(
    parameter int AW = 10
);
    logic          sclk;
    logic          cs;
    logic          mosi;
    logic          miso;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_data;

    modport master (
        output sclk,
        output cs,
        output mosi,
        output mem_data,
        input  miso,
        input  mem_addr
    );

    modport slave (
        input  sclk,
        input  cs,
        input  mosi,
        input  mem_data,
        output miso,
        output mem_addr
    );
endinterface

// File: rtl/sd_spi_responder.sv
// ---------------------------------------------------------------------------
// sd_spi_responder
//   SPI-mode SD card emulator (card end of the link). Oversamples the host
//   SPI pins in the system clock domain, decodes 6-byte command frames,
//   answers the init sequence (CMD0, CMD8, CMD55/ACMD41, CMD58) and serves
//   CMD17 single-block reads from a synchronous byte memory.
//
//   Ports:
//     clock    system clock, at least 8x the host sclk
//     reset    synchronous, active-high
//     bus      sd_spi_responder_if.slave: sclk, cs, mosi, miso,
//              mem_addr, mem_data
//     cmd_stb  one-clock pulse when a full command frame has been received
//     cmd_idx  index of the last received command
//     ready    1 once ACMD41 has answered 0x00
//
//   Optional build macro:
//     SD_CRC16_EN  when defined, the two bytes after a data block carry the
//                  CRC16-CCITT (poly 0x1021, init 0) of the 512 data bytes;
//                  otherwise they are 0xFF, 0xFF and no CRC logic exists.
// ---------------------------------------------------------------------------
module sd_spi_responder #(
    parameter int AW         = 10,
    parameter int INIT_POLLS = 2,
    parameter int NCR        = 1,
    parameter int NAC        = 2,
    parameter int SDHC       = 1
) (
    input  logic                 clock,
    input  logic                 reset,
    sd_spi_responder_if.slave    bus,
    output logic                 cmd_stb,
    output logic [5:0]           cmd_idx,
    output logic                 ready
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_NCR,
        S_RESP,
        S_GAP,
        S_TOKEN,
        S_DATA,
        S_CRC
    } state_t;

    localparam logic SDHC_BIT = (SDHC != 0);

    state_t state, state_nxt;

    logic sclk_p0, sclk_p1, sclk_p2;
    logic cs_p0, cs_p1;
    logic mosi_p0, mosi_p1;
    logic sclk_rise, sclk_fall, cs_act;

    logic [2:0]    bit_cnt;
    logic [6:0]    rx_sr;
    logic [7:0]    rx_byte;
    logic          byte_done;
    logic [7:0]    tx_sr;
    logic          miso_q;

    logic [8:0]    cnt, cnt_nxt;
    logic [5:0]    hdr;
    logic [31:0]   arg_sr;
    logic [39:0]   resp_q;
    logic [2:0]    resp_len;
    logic          data_pend;
    logic [AW-10:0] blk_q;
    logic [AW-1:0] mem_addr_q;
    logic          fetch_p0, fetch_p1;
    logic [7:0]    nxt_byte;

    logic          app_flag;
    logic [7:0]    poll_cnt;

    // FSM strobes
    logic          load_tx;
    logic [7:0]    tx_nxt;
    logic          hdr_load, arg_shift, exec, resp_pop;
    logic          fetch_first, fetch_next, data_load;

    // Command decode results
    logic          idle_bit;
    logic [7:0]    dec_r1;
    logic [31:0]   dec_tail;
    logic [2:0]    dec_len;
    logic          dec_data, dec_clr, dec_inc, dec_set, dec_app;

    logic [7:0]    crc_hi, crc_lo;

    // ---- stage p0/p1: pin synchronizers, p2 holds previous sclk for edges
    always_ff @(posedge clock) begin
        if (reset) begin
            sclk_p0 <= 1'b0;
            sclk_p1 <= 1'b0;
            sclk_p2 <= 1'b0;
            cs_p0   <= 1'b1;
            cs_p1   <= 1'b1;
        end else begin
            sclk_p0 <= bus.sclk;
            sclk_p1 <= sclk_p0;
            sclk_p2 <= sclk_p1;
            cs_p0   <= bus.cs;
            cs_p1   <= cs_p0;
        end
    end

    always_ff @(posedge clock) begin
        mosi_p0 <= bus.mosi;
        mosi_p1 <= mosi_p0;
    end

    assign sclk_rise = sclk_p1 & ~sclk_p2;
    assign sclk_fall = ~sclk_p1 & sclk_p2;
    assign cs_act    = ~cs_p1;
    assign rx_byte   = {rx_sr, mosi_p1};
    assign byte_done = cs_act & sclk_rise & (bit_cnt == 3'd7);

    // ---- serial shifter: sample on rising sclk, drive miso on falling sclk
    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= S_IDLE;
            cnt     <= '0;
            bit_cnt <= '0;
            tx_sr   <= 8'hFF;
            miso_q  <= 1'b1;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (!cs_act) begin
                bit_cnt <= '0;
                tx_sr   <= 8'hFF;
                miso_q  <= 1'b1;
            end else begin
                if (sclk_fall) begin
                    miso_q <= tx_sr[7];
                    tx_sr  <= {tx_sr[6:0], 1'b1};
                end
                if (sclk_rise) begin
                    bit_cnt <= bit_cnt + 3'd1;
                    if (load_tx) begin
                        tx_sr <= tx_nxt;
                    end
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (sclk_rise) begin
            rx_sr <= rx_byte[6:0];
        end
    end

    // Each completed byte decides what goes out during the following byte;
    // the state names the byte that is currently being shifted out.
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        load_tx     = 1'b0;
        tx_nxt      = 8'hFF;
        hdr_load    = 1'b0;
        arg_shift   = 1'b0;
        exec        = 1'b0;
        resp_pop    = 1'b0;
        fetch_first = 1'b0;
        fetch_next  = 1'b0;
        data_load   = 1'b0;
        if (!cs_act) begin
            state_nxt = S_IDLE;
            cnt_nxt   = '0;
        end else if (state == S_IDLE) begin
            state_nxt = S_CMD;
            cnt_nxt   = '0;
        end else if (byte_done) begin
            load_tx = 1'b1;
            case (state)
                S_CMD: begin
                    if (cnt == 9'd0) begin
                        if (rx_byte[7:6] == 2'b01) begin
                            hdr_load = 1'b1;
                            cnt_nxt  = 9'd1;
                        end
                    end else if (cnt == 9'd5) begin
                        // CRC byte: content ignored, frame complete
                        exec      = 1'b1;
                        state_nxt = S_NCR;
                        cnt_nxt   = 9'd1;
                    end else begin
                        arg_shift = 1'b1;
                        cnt_nxt   = cnt + 9'd1;
                    end
                end
                S_NCR: begin
                    if (cnt == 9'(NCR)) begin
                        tx_nxt    = resp_q[39:32];
                        resp_pop  = 1'b1;
                        state_nxt = S_RESP;
                        cnt_nxt   = 9'd1;
                    end else begin
                        cnt_nxt = cnt + 9'd1;
                    end
                end
                S_RESP: begin
                    if (cnt < 9'(resp_len)) begin
                        tx_nxt   = resp_q[39:32];
                        resp_pop = 1'b1;
                        cnt_nxt  = cnt + 9'd1;
                    end else if (data_pend) begin
                        if (NAC == 0) begin
                            tx_nxt      = 8'hFE;
                            fetch_first = 1'b1;
                            state_nxt   = S_TOKEN;
                        end else begin
                            state_nxt = S_GAP;
                            cnt_nxt   = 9'd1;
                        end
                    end else begin
                        state_nxt = S_CMD;
                        cnt_nxt   = '0;
                    end
                end
                S_GAP: begin
                    if (cnt == 9'(NAC)) begin
                        tx_nxt      = 8'hFE;
                        fetch_first = 1'b1;
                        state_nxt   = S_TOKEN;
                    end else begin
                        cnt_nxt = cnt + 9'd1;
                    end
                end
                S_TOKEN: begin
                    tx_nxt     = nxt_byte;
                    data_load  = 1'b1;
                    fetch_next = 1'b1;
                    state_nxt  = S_DATA;
                    cnt_nxt    = '0;
                end
                S_DATA: begin
                    if (cnt == 9'd511) begin
                        tx_nxt    = crc_hi;
                        state_nxt = S_CRC;
                        cnt_nxt   = '0;
                    end else begin
                        tx_nxt     = nxt_byte;
                        data_load  = 1'b1;
                        fetch_next = 1'b1;
                        cnt_nxt    = cnt + 9'd1;
                    end
                end
                S_CRC: begin
                    if (cnt == 9'd0) begin
                        tx_nxt  = crc_lo;
                        cnt_nxt = 9'd1;
                    end else begin
                        state_nxt = S_CMD;
                        cnt_nxt   = '0;
                    end
                end
                default: begin
                    state_nxt = S_IDLE;
                    cnt_nxt   = '0;
                end
            endcase
        end
    end

    // ---- command capture
    always_ff @(posedge clock) begin
        if (hdr_load) begin
            hdr <= rx_byte[5:0];
        end
        if (arg_shift) begin
            arg_sr <= {arg_sr[23:0], rx_byte};
        end
        if (exec) begin
            resp_q <= {dec_r1, dec_tail};
            blk_q  <= arg_sr[AW-10:0];
        end else if (resp_pop) begin
            resp_q <= {resp_q[31:0], 8'hFF};
        end
    end

    assign idle_bit = ~ready;

    always_comb begin
        dec_r1   = 8'h04 | {7'd0, idle_bit};
        dec_tail = 32'hFFFF_FFFF;
        dec_len  = 3'd1;
        dec_data = 1'b0;
        dec_clr  = 1'b0;
        dec_inc  = 1'b0;
        dec_set  = 1'b0;
        dec_app  = 1'b0;
        case (hdr)
            6'd0: begin
                dec_r1  = 8'h01;
                dec_clr = 1'b1;
            end
            6'd8: begin
                dec_r1   = {7'd0, idle_bit};
                dec_tail = {16'h0000, 4'h0, arg_sr[11:8], arg_sr[7:0]};
                dec_len  = 3'd5;
            end
            6'd55: begin
                dec_r1  = {7'd0, idle_bit};
                dec_app = 1'b1;
            end
            6'd41: begin
                // without a preceding CMD55 this is an illegal command
                if (app_flag) begin
                    if (poll_cnt < 8'(INIT_POLLS)) begin
                        dec_r1  = 8'h01;
                        dec_inc = 1'b1;
                    end else begin
                        dec_r1  = 8'h00;
                        dec_set = 1'b1;
                    end
                end
            end
            6'd58: begin
                dec_r1   = {7'd0, idle_bit};
                dec_tail = {1'b1, SDHC_BIT, 6'h3F, 8'hFF, 8'h80, 8'h00};
                dec_len  = 3'd5;
            end
            6'd17: begin
                if (ready) begin
                    dec_r1   = 8'h00;
                    dec_data = 1'b1;
                end else begin
                    dec_r1 = 8'h05;
                end
            end
            default: begin
                dec_r1 = 8'h04 | {7'd0, idle_bit};
            end
        endcase
    end

    // ---- card state: survives cs deassertion, cleared only by reset/CMD0
    always_ff @(posedge clock) begin
        if (reset) begin
            cmd_stb   <= 1'b0;
            cmd_idx   <= '0;
            ready     <= 1'b0;
            app_flag  <= 1'b0;
            poll_cnt  <= '0;
            data_pend <= 1'b0;
            resp_len  <= 3'd1;
        end else begin
            cmd_stb <= exec;
            if (exec) begin
                cmd_idx   <= hdr;
                app_flag  <= dec_app;
                data_pend <= dec_data;
                resp_len  <= dec_len;
                if (dec_clr) begin
                    ready    <= 1'b0;
                    poll_cnt <= '0;
                end
                if (dec_inc) begin
                    poll_cnt <= poll_cnt + 8'd1;
                end
                if (dec_set) begin
                    ready <= 1'b1;
                end
            end
        end
    end

    // ---- memory fetch: p0 = address driven, p1 = data valid at the RAM port
    always_ff @(posedge clock) begin
        if (reset) begin
            mem_addr_q <= '0;
            fetch_p0   <= 1'b0;
            fetch_p1   <= 1'b0;
        end else begin
            fetch_p0 <= fetch_first | fetch_next;
            fetch_p1 <= fetch_p0;
            if (fetch_first) begin
                mem_addr_q <= {blk_q, 9'd0};
            end else if (fetch_next) begin
                // 9-bit index wraps inside the block
                mem_addr_q[8:0] <= mem_addr_q[8:0] + 9'd1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (fetch_p1) begin
            nxt_byte <= bus.mem_data;
        end
    end

`ifdef SD_CRC16_EN
    logic [15:0] crc_q;

    function automatic logic [15:0] crc16_byte(input logic [15:0] c, input logic [7:0] d);
        logic [15:0] r;
        r = c ^ {d, 8'h00};
        for (int i = 0; i < 8; i++) begin
            r = r[15] ? ((r << 1) ^ 16'h1021) : (r << 1);
        end
        return r;
    endfunction

    // ---- CRC accumulates each data byte as it is loaded into the shifter
    always_ff @(posedge clock) begin
        if (fetch_first) begin
            crc_q <= '0;
        end else if (data_load) begin
            crc_q <= crc16_byte(crc_q, tx_nxt);
        end
    end

    assign crc_hi = crc_q[15:8];
    assign crc_lo = crc_q[7:0];
`else
    logic unused_data_load;
    assign unused_data_load = data_load;
    assign crc_hi = 8'hFF;
    assign crc_lo = 8'hFF;
`endif

    logic unused_arg;
    assign unused_arg = ^arg_sr;

    assign bus.miso     = miso_q;
    assign bus.mem_addr = mem_addr_q;

endmodule

// File: tb/tb_sd_spi_responder.sv
// ---------------------------------------------------------------------------
// tb_sd_spi_responder
//   Directed bench for the SD SPI card emulator. A host model clocks bytes
//   over the interface at clock/8; expected card bytes are queued as each
//   command is issued and compared as they are clocked back.
// ---------------------------------------------------------------------------
module tb_sd_spi_responder;

    localparam int AW         = 10;
    localparam int INIT_POLLS = 2;
    localparam int NCR        = 1;
    localparam int NAC        = 2;
    localparam int SDHC       = 1;
    localparam int HALF       = 4;

    logic       clock = 1'b0;
    logic       reset;
    logic       cmd_stb;
    logic [5:0] cmd_idx;
    logic       ready;

    always #5 clock = ~clock;

    sd_spi_responder_if #(.AW(AW)) bus_if ();

    sd_spi_responder #(
        .AW(AW), .INIT_POLLS(INIT_POLLS), .NCR(NCR), .NAC(NAC), .SDHC(SDHC)
    ) dut (
        .clock   (clock),
        .reset   (reset),
        .bus     (bus_if),
        .cmd_stb (cmd_stb),
        .cmd_idx (cmd_idx),
        .ready   (ready)
    );

    logic [7:0] mem [0:1023];
    logic [7:0] mem_rd;

    always @(posedge clock) mem_rd <= mem[bus_if.mem_addr];
    assign bus_if.mem_data = mem_rd;

    int tests = 0;
    int fails = 0;
    int stb_cnt = 0;

    always @(posedge clock) if (cmd_stb === 1'b1) stb_cnt <= stb_cnt + 1;

    logic [7:0] exp_q[$];
    string      tag_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx);
        for (int i = 7; i >= 0; i--) begin
            bus_if.mosi = tx[i];
            repeat (HALF) @(negedge clock);
            rx[i] = bus_if.miso;
            bus_if.sclk = 1'b1;
            repeat (HALF) @(negedge clock);
            bus_if.sclk = 1'b0;
        end
    endtask

    task automatic send_cmd(input logic [5:0] idx, input logic [31:0] arg, input logic [7:0] crc);
        logic [7:0] d;
        spi_byte({2'b01, idx}, d);
        spi_byte(arg[31:24], d);
        spi_byte(arg[23:16], d);
        spi_byte(arg[15:8], d);
        spi_byte(arg[7:0], d);
        spi_byte(crc, d);
    endtask

    task automatic push(input string tag, input logic [7:0] b);
        exp_q.push_back(b);
        tag_q.push_back(tag);
    endtask

    task automatic push_fill(input string tag);
        for (int i = 0; i < NCR; i++) push({tag, "_ncr"}, 8'hFF);
    endtask

    task automatic drain();
        logic [7:0] d;
        logic [7:0] e;
        string      t;
        while (exp_q.size() > 0) begin
            spi_byte(8'hFF, d);
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            check(t, {24'd0, d}, {24'd0, e});
        end
    endtask

    task automatic push_read_head(input string tag);
        push_fill(tag);
        push({tag, "_r1"}, 8'h00);
        for (int i = 0; i < NAC; i++) push({tag, "_nac"}, 8'hFF);
        push({tag, "_token"}, 8'hFE);
    endtask

    initial begin
        logic [7:0]  d;
        int          s0;
        int          polls_m;
        logic        rdy_m;
        logic [15:0] crc_m;

        for (int i = 0; i < 1024; i++) mem[i] = 8'(i) ^ 8'h5A;
        reset       = 1'b1;
        bus_if.sclk = 1'b0;
        bus_if.cs   = 1'b1;
        bus_if.mosi = 1'b1;
        repeat (4) @(negedge clock);

        check("rst_miso", {31'd0, bus_if.miso}, 32'd1);
        check("rst_mem_addr", {22'd0, bus_if.mem_addr}, 32'd0);
        check("rst_cmd_stb", {31'd0, cmd_stb}, 32'd0);
        check("rst_cmd_idx", {26'd0, cmd_idx}, 32'd0);
        check("rst_ready", {31'd0, ready}, 32'd0);
        reset = 1'b0;
        repeat (2) @(negedge clock);

        // 80 clocks with cs high
        for (int i = 0; i < 10; i++) spi_byte(8'hFF, d);
        check("precs_miso", {24'd0, d}, 32'hFF);
        bus_if.cs = 1'b0;
        repeat (4) @(negedge clock);

        // CMD0
        s0 = stb_cnt;
        send_cmd(6'd0, 32'h0, 8'h95);
        push_fill("cmd0");
        push("cmd0_r1", 8'h01);
        drain();
        check("cmd0_stb_count", stb_cnt - s0, 32'd1);
        check("cmd0_idx", {26'd0, cmd_idx}, 32'd0);

        // CMD17 before init: illegal-state reply, no token follows
        send_cmd(6'd17, 32'h1, 8'hFF);
        push_fill("cmd17_early");
        push("cmd17_early_r1", 8'h05);
        for (int i = 0; i < 4; i++) push("cmd17_no_token", 8'hFF);
        drain();

        // Unsupported CMD5
        send_cmd(6'd5, 32'h0, 8'hFF);
        push_fill("cmd5");
        push("cmd5_r1", 8'h05);
        drain();
        check("cmd5_idx", {26'd0, cmd_idx}, 32'd5);

        // CMD8 echo
        send_cmd(6'd8, 32'h0000_01AA, 8'h87);
        push_fill("cmd8");
        push("cmd8_r1", 8'h01);
        push("cmd8_b1", 8'h00);
        push("cmd8_b2", 8'h00);
        push("cmd8_vhs", 8'h01);
        push("cmd8_pat", 8'hAA);
        drain();

        // CMD55 + ACMD41 polling
        polls_m = 0;
        rdy_m   = 1'b0;
        for (int k = 0; k <= INIT_POLLS; k++) begin
            send_cmd(6'd55, 32'h0, 8'hFF);
            push_fill("cmd55");
            push("cmd55_r1", {7'd0, ~rdy_m});
            drain();
            send_cmd(6'd41, 32'h4000_0000, 8'hFF);
            push_fill("acmd41");
            if (polls_m < INIT_POLLS) begin
                push("acmd41_r1", 8'h01);
                polls_m++;
            end else begin
                push("acmd41_r1", 8'h00);
                rdy_m = 1'b1;
            end
            drain();
        end
        check("ready_after_init", {31'd0, ready}, {31'd0, rdy_m});

        // CMD58 OCR
        send_cmd(6'd58, 32'h0, 8'hFF);
        push_fill("cmd58");
        push("cmd58_r1", 8'h00);
        push("cmd58_ocr3", {1'b1, 1'(SDHC), 6'h3F});
        push("cmd58_ocr2", 8'hFF);
        push("cmd58_ocr1", 8'h80);
        push("cmd58_ocr0", 8'h00);
        drain();

        // CMD41 without CMD55 is illegal; app flag cleared by CMD58
        send_cmd(6'd41, 32'h0, 8'hFF);
        push_fill("cmd41_noapp");
        push("cmd41_noapp_r1", 8'h04);
        drain();

        // CMD17 full block 1
        send_cmd(6'd17, 32'h1, 8'hFF);
        push_read_head("rd1");
        crc_m = 16'h0000;
        for (int i = 0; i < 512; i++) begin
            push("rd1_data", mem[512 + i]);
            for (int b = 7; b >= 0; b--) begin
                if (crc_m[15] ^ mem[512 + i][b]) crc_m = (crc_m << 1) ^ 16'h1021;
                else crc_m = crc_m << 1;
            end
        end
`ifdef SD_CRC16_EN
        push("rd1_crc_hi", crc_m[15:8]);
        push("rd1_crc_lo", crc_m[7:0]);
`else
        push("rd1_crc_hi", 8'hFF);
        push("rd1_crc_lo", 8'hFF);
`endif
        push("rd1_after", 8'hFF);
        drain();

        // CMD17 aborted after 100 data bytes
        send_cmd(6'd17, 32'h1, 8'hFF);
        push_read_head("rd2");
        for (int i = 0; i < 100; i++) push("rd2_data", mem[512 + i]);
        drain();
        repeat (3) @(negedge clock);
        check("abort_pre_miso", {31'd0, bus_if.miso}, {31'd0, mem[612][7]});
        bus_if.cs = 1'b1;
        repeat (3) @(negedge clock);
        check("abort_miso", {31'd0, bus_if.miso}, 32'd1);
        check("abort_ready", {31'd0, ready}, 32'd1);
        repeat (8) @(negedge clock);
        bus_if.cs = 1'b0;
        repeat (4) @(negedge clock);

        // Restarted read begins at byte 0
        send_cmd(6'd17, 32'h1, 8'hFF);
        push_read_head("rd3");
        for (int i = 0; i < 16; i++) push("rd3_data", mem[512 + i]);
        drain();
        check("rd3_ready", {31'd0, ready}, 32'd1);
        bus_if.cs = 1'b1;
        repeat (4) @(negedge clock);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
